ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Multi-cycle, parametrised control unit for the processor. It replaces the single-cycle PC/instruction-memory/decoder arrangement with a sequenced FETCH→EXEC machine. Instructions are fetched over a req/ack handshake from an external instruction memory, so memory may take any number of cycles. It adds branch-on-negative, a HALT instruction and a run/halted start–stop interface, and sits between the instruction memory and the datapath.

## Interface
Parameters:
- BUS_WIDTH, 16: datapath and PC width (≥ 8)
- RESET_VECTOR, 0: PC value loaded on reset

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  start pulse; honoured only in IDLE or HALTED
- imem_req  out  1  fetch request
- imem_addr  out  BUS_WIDTH  fetch address, equal to PC
- imem_ack  in  1  fetch complete; imem_rdata is valid in this cycle
- imem_rdata  in  16  instruction word
- dp_eu_zero  in  1  datapath zero flag
- dp_eu_neg  in  1  datapath negative flag
- dp_address_out  in  BUS_WIDTH  register A value, used as the jump target
- MB, RW, MD, MW  out  1 each  datapath controls
- op_select  out  4  execution-unit function
- rd, rsA, rsB  out  3 each  register selects
- constant_in  out  3  IR[2:0]
- halted  out  1  high in the HALTED state

## Operation
- Instruction fields: IR[8:6]=rd, IR[5:3]=rsA, IR[2:0]=rsB. The existing decoder mapping produces MB/RW/MD/MW/op_select/PL/JB/BC.
- HALT encoding: IR[15:9] = 7'h7F, which overrides the decoder.
- States:
  - IDLE (reset state): run → FETCH.
  - FETCH: imem_req=1. On imem_ack, IR <= imem_rdata; → EXEC.
  - EXEC: lasts one cycle and updates PC. If the instruction is HALT → HALTED with PC unchanged; otherwise → FETCH.
  - HALTED: run → FETCH, resuming at the PC.
- Next-PC rules in EXEC:
  - PL=1, JB=1 (jump): PC <= dp_address_out.
  - PL=1, JB=0 (branch): taken if (BC=0 and dp_eu_zero) or (BC=1 and dp_eu_neg). Taken: PC <= PC + sign_ext({IR[8:6],IR[2:0]}). Not taken: PC <= PC+1.
  - PL=0: PC <= PC+1.
- Arithmetic is modulo 2^BUS_WIDTH: PC at all-ones +1 wraps to 0, and negative offsets wrap below 0. The 6-bit offset range is −32..+31.
- RW and MW are asserted only in EXEC. In every other state RW=MW=0 so no datapath write occurs. MB, MD, op_select, rd, rsA, rsB and constant_in are decoded from IR at all times.
- Boundary conditions:
  - imem_ack outside FETCH is ignored.
  - run outside IDLE/HALTED is ignored.
  - run held high in HALTED restarts on the next cycle.
  - imem_ack is accepted on the same cycle imem_req rises.
  - HALT with PL=1 in the decoder still halts, with no PC change.

## Timing
- Reset values: state=IDLE, PC=RESET_VECTOR, IR=16'h0000, imem_req=0, RW=MW=0, halted=0. Other outputs take the values decoded from IR=0.
- Reset asserted mid-fetch or mid-EXEC drops imem_req and RW/MW immediately, without waiting for a clock edge.
- imem_req is a registered (Moore) output. It rises the cycle after entry to FETCH is decided, and falls on the edge that samples imem_ack.
- Minimum instruction latency is 2 cycles: FETCH with ack in the same cycle, then EXEC. Each wait cycle adds one.
- Flags and dp_address_out are sampled at the EXEC clock edge.

## Configuration
- CTRL_TDO_EN defined: adds three outputs.
  - tdo_instr_addr (BUS_WIDTH): PC of the instruction in IR.
  - tdo_instruction (16): the IR.
  - tdo_retired (32): count of EXEC cycles, reset to 0, wraps at 2^32.
- CTRL_TDO_EN undefined: these ports and their registers are absent, and the functional behaviour is otherwise identical.

## Structure
- Shared package holds:
  - the state enum (IDLE, FETCH, EXEC, HALTED);
  - the HALT opcode constant 7'h7F;
  - the instruction field bit positions;
  - the offset width 6.
- Sub-module: instr_dec, the existing combinational decoder, instantiated on IR. Next-PC logic and the FSM stay in ctrl_seq.

## Test plan
- Reset, run pulse, ack on the same cycle each fetch, three non-branch instructions → imem_addr 0,1,2. RW pulses exactly once per EXEC.
- imem_ack delayed 3 cycles → imem_req held for 4 cycles. IR is unchanged until ack and RW=0 throughout the wait.
- Branch at PC=0x0010, offset 6'b111110, dp_eu_zero=1, BC=0 → next imem_addr 0x000E. Repeat with zero=0 → 0x0011.
- BC=1 branch at PC=0xFFFF, offset +1, dp_eu_neg=1 → PC wraps to 0x0000. Jump with dp_address_out=0x1234 → 0x1234.
- HALT at PC=5 → halted=1, imem_req=0 held for 10 cycles. Run pulse → fetch from PC=5. Reset asserted while imem_req=1 → imem_req=0 with no clock edge, PC=RESET_VECTOR.
- With CTRL_TDO_EN, four retired instructions → tdo_retired=4, and tdo_instr_addr tracks each EXEC PC.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_seq_pkg
// Shared definitions for the sequenced control unit:
//   - FSM state encoding (IDLE, FETCH, EXEC, HALTED)
//   - HALT opcode and instruction field bit positions
//   - branch offset width and decoder opcode classes
// No ports (package).
// -----------------------------------------------------------------------------
package ctrl_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      EXEC   = 2'd2,
      HALTED = 2'd3
   } state_t;

   localparam logic [6:0] HALT_OPCODE = 7'h7F;

   // Instruction word layout
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 9;
   localparam int RD_MSB  = 8;
   localparam int RD_LSB  = 6;
   localparam int RSA_MSB = 5;
   localparam int RSA_LSB = 3;
   localparam int RSB_MSB = 2;
   localparam int RSB_LSB = 0;

   // Branch offset is {rd field, rsB field}, two's complement
   localparam int OFFSET_W = 6;

   // Opcode class lives in opcode[6:4]; opcode[3:0] carries the EU function
   localparam logic [2:0] CLS_ALU  = 3'b000;
   localparam logic [2:0] CLS_LD   = 3'b001;
   localparam logic [2:0] CLS_ST   = 3'b010;
   localparam logic [2:0] CLS_ALUI = 3'b100;
   localparam logic [2:0] CLS_BR   = 3'b110;
   localparam logic [2:0] CLS_JMP  = 3'b111;

   function automatic logic is_halt(input logic [6:0] opcode);
      return (opcode == HALT_OPCODE);
   endfunction

endpackage

// File: rtl/ctrl_seq_instr_dec.sv
// -----------------------------------------------------------------------------
// instr_dec
// Combinational instruction decoder (opcode -> datapath/branch controls).
// Ports:
//   i_opcode    in  7  IR[15:9]
//   o_mb        out 1  B operand from constant
//   o_md        out 1  write-back from memory
//   o_rw        out 1  register write (gated by the sequencer)
//   o_mw        out 1  memory write   (gated by the sequencer)
//   o_op_select out 4  execution-unit function
//   o_pl        out 1  PC load (branch or jump)
//   o_jb        out 1  1 = jump, 0 = branch
//   o_bc        out 1  branch condition: 0 = zero, 1 = negative
// -----------------------------------------------------------------------------
module instr_dec
   import ctrl_seq_pkg::*;
(
   input  logic [6:0] i_opcode,
   output logic       o_mb,
   output logic       o_md,
   output logic       o_rw,
   output logic       o_mw,
   output logic [3:0] o_op_select,
   output logic       o_pl,
   output logic       o_jb,
   output logic       o_bc
);

   always_comb begin
      o_mb        = 1'b0;
      o_md        = 1'b0;
      o_rw        = 1'b0;
      o_mw        = 1'b0;
      o_op_select = 4'h0;
      o_pl        = 1'b0;
      o_jb        = 1'b0;
      o_bc        = 1'b0;
      case (i_opcode[6:4])
         CLS_ALU: begin
            o_rw        = 1'b1;
            o_op_select = i_opcode[3:0];
         end
         CLS_LD: begin
            o_rw = 1'b1;
            o_md = 1'b1;
         end
         CLS_ST: begin
            o_mw = 1'b1;
         end
         CLS_ALUI: begin
            o_rw        = 1'b1;
            o_mb        = 1'b1;
            o_op_select = i_opcode[3:0];
         end
         CLS_BR: begin
            o_pl = 1'b1;
            o_bc = i_opcode[0];
         end
         CLS_JMP: begin
            o_pl = 1'b1;
            o_jb = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ctrl_seq.sv
// -----------------------------------------------------------------------------
// ctrl_seq
// Multi-cycle FETCH -> EXEC control unit with req/ack instruction fetch,
// branch-on-zero/negative, jump, HALT and run/halted start-stop.
// Optional trace outputs enabled by defining CTRL_TDO_EN.
// Ports:
//   clk, reset(async, active-low), run (start pulse in IDLE/HALTED)
//   imem_req/imem_addr out, imem_ack/imem_rdata in : instruction fetch
//   dp_eu_zero, dp_eu_neg, dp_address_out in       : datapath flags / jump target
//   MB, RW, MD, MW, op_select, rd, rsA, rsB, constant_in out : datapath controls
//   halted out                                      : high in HALTED
//   [CTRL_TDO_EN] tdo_instr_addr, tdo_instruction, tdo_retired out : trace
// -----------------------------------------------------------------------------
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int                   BUS_WIDTH    = 16,
   parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = '0
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   output logic                 imem_req,
   output logic [BUS_WIDTH-1:0] imem_addr,
   input  logic                 imem_ack,
   input  logic [15:0]          imem_rdata,
   input  logic                 dp_eu_zero,
   input  logic                 dp_eu_neg,
   input  logic [BUS_WIDTH-1:0] dp_address_out,
   output logic                 MB,
   output logic                 RW,
   output logic                 MD,
   output logic                 MW,
   output logic [3:0]           op_select,
   output logic [2:0]           rd,
   output logic [2:0]           rsA,
   output logic [2:0]           rsB,
   output logic [2:0]           constant_in,
   output logic                 halted
`ifdef CTRL_TDO_EN
   ,
   output logic [BUS_WIDTH-1:0] tdo_instr_addr,
   output logic [15:0]          tdo_instruction,
   output logic [31:0]          tdo_retired
`endif
);

   localparam logic [BUS_WIDTH-1:0] PC_ONE = {{(BUS_WIDTH-1){1'b0}}, 1'b1};

   state_t               r_state;
   state_t               w_state_next;
   logic                 r_imem_req;
   logic [BUS_WIDTH-1:0] r_pc;
   logic [BUS_WIDTH-1:0] w_pc_next;
   logic [15:0]          r_ir;
   logic                 w_ir_load;

   logic                 w_mb, w_md, w_rw, w_mw, w_pl, w_jb, w_bc;
   logic [3:0]           w_op_select;
   logic                 w_is_halt;
   logic                 w_taken;
   logic [OFFSET_W-1:0]  w_offset;
   logic [BUS_WIDTH-1:0] w_offset_ext;

   instr_dec u_dec (
      .i_opcode    (r_ir[OPC_MSB:OPC_LSB]),
      .o_mb        (w_mb),
      .o_md        (w_md),
      .o_rw        (w_rw),
      .o_mw        (w_mw),
      .o_op_select (w_op_select),
      .o_pl        (w_pl),
      .o_jb        (w_jb),
      .o_bc        (w_bc)
   );

   assign w_is_halt    = is_halt(r_ir[OPC_MSB:OPC_LSB]);
   assign w_taken      = (~w_bc & dp_eu_zero) | (w_bc & dp_eu_neg);
   assign w_offset     = {r_ir[RD_MSB:RD_LSB], r_ir[RSB_MSB:RSB_LSB]};
   assign w_offset_ext = {{(BUS_WIDTH-OFFSET_W){w_offset[OFFSET_W-1]}}, w_offset};

   // Next-state / next-PC
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_ir_load    = 1'b0;
      case (r_state)
         IDLE, HALTED: begin
            if (run) w_state_next = FETCH;
         end
         FETCH: begin
            if (imem_ack) begin
               w_ir_load    = 1'b1;
               w_state_next = EXEC;
            end
         end
         EXEC: begin
            // HALT wins over whatever PL/JB the decoder reports for it
            if (w_is_halt) begin
               w_state_next = HALTED;
            end else begin
               w_state_next = FETCH;
               if (w_pl && w_jb)
                  w_pc_next = dp_address_out;
               else if (w_pl && w_taken)
                  w_pc_next = r_pc + w_offset_ext;
               else
                  w_pc_next = r_pc + PC_ONE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_imem_req <= 1'b0;
         r_pc       <= RESET_VECTOR;
         r_ir       <= 16'h0000;
      end else begin
         r_state    <= w_state_next;
         // Registered request: high exactly while the FSM sits in FETCH
         r_imem_req <= (w_state_next == FETCH);
         r_pc       <= w_pc_next;
         if (w_ir_load) r_ir <= imem_rdata;
      end
   end

   assign imem_req    = r_imem_req;
   assign imem_addr   = r_pc;
   assign halted      = (r_state == HALTED);
   // Writes are only allowed during EXEC; reset forces IDLE asynchronously
   assign RW          = (r_state == EXEC) & w_rw & ~w_is_halt;
   assign MW          = (r_state == EXEC) & w_mw & ~w_is_halt;
   assign MB          = w_mb;
   assign MD          = w_md;
   assign op_select   = w_op_select;
   assign rd          = r_ir[RD_MSB:RD_LSB];
   assign rsA         = r_ir[RSA_MSB:RSA_LSB];
   assign rsB         = r_ir[RSB_MSB:RSB_LSB];
   assign constant_in = r_ir[RSB_MSB:RSB_LSB];

`ifdef CTRL_TDO_EN
   logic [BUS_WIDTH-1:0] r_tdo_addr;
   logic [31:0]          r_retired;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tdo_addr <= RESET_VECTOR;
         r_retired  <= 32'd0;
      end else begin
         // Capture the PC alongside the instruction so the pair stays coherent
         if (w_ir_load)         r_tdo_addr <= r_pc;
         if (r_state == EXEC)   r_retired  <= r_retired + 32'd1;
      end
   end

   assign tdo_instr_addr  = r_tdo_addr;
   assign tdo_instruction = r_ir;
   assign tdo_retired     = r_retired;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_ctrl_seq
// Directed stimulus for ctrl_seq with hand-computed expectations.
// Instruction encodings used (opcode = IR[15:9], class = opcode[6:4]):
//   16'h0453 ALU op 2,  rd=1 rsA=2 rsB=3      -> RW, op_select=2
//   16'h8B2E ALUI op 5, rd=4 rsA=5 rsB=6      -> RW, MB, op_select=5
//   16'h41C0 ST, rd=7                         -> MW
//   16'hC1C6 BZ offset 6'b111110 (-2)
//   16'hC201 BN offset +1
//   16'hE000 JMP (target = dp_address_out)
//   16'hFE00 HALT
// -----------------------------------------------------------------------------
module tb_ctrl_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        dp_eu_zero;
   logic        dp_eu_neg;
   logic [15:0] dp_address_out;
   logic        MB, RW, MD, MW;
   logic [3:0]  op_select;
   logic [2:0]  rd, rsA, rsB, constant_in;
   logic        halted;
`ifdef CTRL_TDO_EN
   logic [15:0] tdo_instr_addr;
   logic [15:0] tdo_instruction;
   logic [31:0] tdo_retired;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ctrl_seq #(
      .BUS_WIDTH    (16),
      .RESET_VECTOR (16'h0000)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .run            (run),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .dp_eu_zero     (dp_eu_zero),
      .dp_eu_neg      (dp_eu_neg),
      .dp_address_out (dp_address_out),
      .MB             (MB),
      .RW             (RW),
      .MD             (MD),
      .MW             (MW),
      .op_select      (op_select),
      .rd             (rd),
      .rsA            (rsA),
      .rsB            (rsB),
      .constant_in    (constant_in),
      .halted         (halted)
`ifdef CTRL_TDO_EN
      ,
      .tdo_instr_addr  (tdo_instr_addr),
      .tdo_instruction (tdo_instruction),
      .tdo_retired     (tdo_retired)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance one clock; return 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an instruction with ack in the current FETCH cycle; returns in EXEC
   task automatic fetch(input logic [15:0] instr);
      imem_ack   = 1'b1;
      imem_rdata = instr;
      step();
      imem_ack   = 1'b0;
   endtask

   task automatic do_jump(input logic [15:0] target);
      fetch(16'hE000);
      dp_address_out = target;
      step();
      chk("jump_addr", imem_addr, target);
   endtask

   initial begin
      reset          = 1'b0;
      run            = 1'b0;
      imem_ack       = 1'b0;
      imem_rdata     = 16'h0000;
      dp_eu_zero     = 1'b0;
      dp_eu_neg      = 1'b0;
      dp_address_out = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      // Reset state
      chk("rst_req",    imem_req,  0);
      chk("rst_addr",   imem_addr, 16'h0000);
      chk("rst_rw",     RW,        0);
      chk("rst_mw",     MW,        0);
      chk("rst_halted", halted,    0);
      chk("rst_op",     op_select, 0);
      chk("rst_rd",     rd,        0);
      chk("rst_mb",     MB,        0);
      chk("rst_md",     MD,        0);
      step();
      chk("idle_noreq", imem_req,  0);

      // Start
      run = 1'b1;
      step();
      run = 1'b0;
      chk("run_req",  imem_req,  1);
      chk("run_addr", imem_addr, 16'h0000);

      // Instruction A: ALU op 2
      fetch(16'h0453);
      chk("A_rw",  RW,          1);
      chk("A_mw",  MW,          0);
      chk("A_op",  op_select,   2);
      chk("A_rd",  rd,          1);
      chk("A_rsa", rsA,         2);
      chk("A_rsb", rsB,         3);
      chk("A_k",   constant_in, 3);
      chk("A_mb",  MB,          0);
      chk("A_req", imem_req,    0);
`ifdef CTRL_TDO_EN
      chk("A_tdo_addr", tdo_instr_addr, 16'h0000);
`endif
      step();
      chk("A_next_req",  imem_req,  1);
      chk("A_next_addr", imem_addr, 16'h0001);
      chk("A_next_rw",   RW,        0);

      // Instruction B: ALU immediate op 5
      fetch(16'h8B2E);
      chk("B_rw", RW,        1);
      chk("B_mb", MB,        1);
      chk("B_op", op_select, 5);
      chk("B_rd", rd,        4);
`ifdef CTRL_TDO_EN
      chk("B_tdo_addr", tdo_instr_addr, 16'h0001);
`endif
      step();
      chk("B_next_addr", imem_addr, 16'h0002);

      // Instruction C: store, rd=7
      fetch(16'h41C0);
      chk("C_mw", MW, 1);
      chk("C_rw", RW, 0);
      chk("C_rd", rd, 7);
      step();
      chk("C_next_addr", imem_addr, 16'h0003);
      chk("C_next_mw",   MW,        0);
      chk("C_next_req",  imem_req,  1);

      // Instruction D: ack held off for 3 cycles; run pulsed meanwhile is ignored
      for (int i = 0; i < 3; i++) begin
         run = 1'b1;
         step();
         chk("wait_req", imem_req, 1);
         chk("wait_rw",  RW,       0);
         chk("wait_ir",  rd,       7);
      end
      run = 1'b0;
      fetch(16'h0453);
      chk("D_rd",  rd,       1);
      chk("D_req", imem_req, 0);
      chk("D_rw",  RW,       1);
      // ack during EXEC must be ignored
      imem_ack   = 1'b1;
      imem_rdata = 16'hFE00;
      step();
      imem_ack   = 1'b0;
      chk("D_next_addr",  imem_addr, 16'h0004);
      chk("ack_exec_ir",  rd,        1);
      chk("ack_exec_hlt", halted,    0);
      chk("D_next_req",   imem_req,  1);
`ifdef CTRL_TDO_EN
      chk("tdo_retired4", tdo_retired,     4);
      chk("tdo_addr_D",   tdo_instr_addr,  16'h0003);
      chk("tdo_instr_D",  tdo_instruction, 16'h0453);
`endif

      // Branch on zero, taken backwards from 0x0010
      do_jump(16'h0010);
      fetch(16'hC1C6);
      chk("bz_rw", RW, 0);
      dp_eu_zero = 1'b1;
      step();
      dp_eu_zero = 1'b0;
      chk("bz_taken", imem_addr, 16'h000E);

      // Same branch, zero clear (neg set must not matter for BC=0)
      do_jump(16'h0010);
      fetch(16'hC1C6);
      dp_eu_neg = 1'b1;
      step();
      dp_eu_neg = 1'b0;
      chk("bz_not_taken", imem_addr, 16'h0011);

      // Branch on negative at 0xFFFF, +1 wraps to 0
      do_jump(16'hFFFF);
      fetch(16'hC201);
      dp_eu_neg = 1'b1;
      step();
      dp_eu_neg = 1'b0;
      chk("bn_wrap", imem_addr, 16'h0000);

      do_jump(16'h1234);
      do_jump(16'h0005);

      // HALT at PC=5; decoder reports a jump but PC must stay
      fetch(16'hFE00);
      dp_address_out = 16'hAAAA;
      chk("halt_exec_rw", RW, 0);
      step();
      chk("halt_halted", halted,    1);
      chk("halt_req",    imem_req,  0);
      chk("halt_pc",     imem_addr, 16'h0005);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("halt_hold",     halted,   1);
         chk("halt_hold_req", imem_req, 0);
      end
      run = 1'b1;
      step();
      run = 1'b0;
      chk("resume_halted", halted,    0);
      chk("resume_req",    imem_req,  1);
      chk("resume_addr",   imem_addr, 16'h0005);

      // Asynchronous reset mid-fetch
      reset = 1'b0;
      #1;
      chk("arst_req",  imem_req,  0);
      chk("arst_addr", imem_addr, 16'h0000);
      step();
      reset = 1'b1;

      // run held high across HALTED restarts on the next cycle
      run = 1'b1;
      step();
      chk("run2_req", imem_req, 1);
      fetch(16'hFE00);
      step();
      chk("run_held_halted", halted, 1);
      step();
      chk("run_held_restart", halted,   0);
      chk("run_held_req",     imem_req, 1);
      chk("run_held_addr",    imem_addr, 16'h0000);
      run = 1'b0;

      // Asynchronous reset mid-EXEC drops RW at once
      fetch(16'h0453);
      chk("exec_rw", RW, 1);
      reset = 1'b0;
      #1;
      chk("arst_rw",  RW,       0);
      chk("arst_req2", imem_req, 0);
      step();
      reset = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
